// File: rtl/comnet_reg_arbiter_if.sv
// Register-bus bundle: comnet request/response signals plus the per-slave strobe/response bus.
// master is the arbiter's view; slave is the environment (comnet front end and register slaves).
interface comnet_reg_arbiter_if #(
  parameter int NSLV = 4
);
  logic               wr;
  logic               rd;
  logic [15:0]        addr;
  logic [31:0]        data;
  logic [31:0]        rdata;
  logic               ack;
  logic               nack;
  logic               unknown;
  logic               timeout;
  logic               busy;
  logic [NSLV-1:0]    s_wr;
  logic [NSLV-1:0]    s_rd;
  logic [11:0]        s_addr;
  logic [31:0]        s_wdata;
  logic [NSLV*32-1:0] s_rdata;
  logic [NSLV-1:0]    s_ack;
  logic [NSLV-1:0]    s_nack;

  modport master (
    input  wr, rd, addr, data, s_rdata, s_ack, s_nack,
    output rdata, ack, nack, unknown, timeout, busy, s_wr, s_rd, s_addr, s_wdata
  );

  modport slave (
    output wr, rd, addr, data, s_rdata, s_ack, s_nack,
    input  rdata, ack, nack, unknown, timeout, busy, s_wr, s_rd, s_addr, s_wdata
  );
endinterface

// File: rtl/comnet_reg_arbiter.sv
// Register-bus controller: one comnet wr/rd at a time, strobes slave addr[15:12], returns ack/nack/unknown/timeout.
// Fastest turnaround 4 edges (request E0, response pulse E2..E3); requests arriving while busy are dropped.
module comnet_reg_arbiter #(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_i,
  comnet_reg_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_NACK, RSP_UNKNOWN, RSP_TIMEOUT} resp_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  sel;
    logic [11:0] off;
    logic [31:0] wdata;
  } req_t;

  state_t          r_state, w_state_nxt;
  resp_t           r_resp, w_resp_nxt;
  req_t            r_req;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_pend_ack, r_pend_nack;
  logic            w_pend_ack_nxt, w_pend_nack_nxt;
  logic [31:0]     r_rdata;
  logic            w_accept, w_rdata_load;
  logic            w_req, w_illegal, w_unknown;
  logic            w_sel_ack, w_sel_nack;
  logic [31:0]     w_sel_rdata;
  logic [NSLV-1:0] w_onehot;

  assign w_req     = bus.wr | bus.rd;
  assign w_illegal = bus.wr & bus.rd;
  assign w_unknown = 32'(bus.addr[15:12]) >= 32'(NSLV);

  // Only the latched slave's response lines are ever looked at.
  always_comb begin
    w_onehot    = '0;
    w_sel_ack   = 1'b0;
    w_sel_nack  = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_req.sel == 4'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_ack   = bus.s_ack[i];
        w_sel_nack  = bus.s_nack[i];
        w_sel_rdata = bus.s_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_resp_nxt      = r_resp;
    w_cnt_nxt       = r_cnt;
    w_pend_ack_nxt  = r_pend_ack;
    w_pend_nack_nxt = r_pend_nack;
    w_accept        = 1'b0;
    w_rdata_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept        = 1'b1;
          w_cnt_nxt       = '0;
          w_pend_ack_nxt  = 1'b0;
          w_pend_nack_nxt = 1'b0;
          if (w_illegal) begin
            w_state_nxt = ST_RESP;
            w_resp_nxt  = RSP_NACK;
          end else if (w_unknown) begin
            w_state_nxt = ST_RESP;
            w_resp_nxt  = RSP_UNKNOWN;
          end else begin
            w_state_nxt = ST_STROBE;
          end
        end
      end
      ST_STROBE: begin
        // A response in the strobe cycle is parked and returned from the first WAIT cycle.
        w_state_nxt = ST_WAIT;
        if (w_sel_nack) begin
          w_pend_nack_nxt = 1'b1;
        end else if (w_sel_ack) begin
          w_pend_ack_nxt = 1'b1;
          w_rdata_load   = !r_req.wr;
        end
      end
      ST_WAIT: begin
        w_state_nxt = ST_RESP;
        if (r_pend_nack) begin
          w_resp_nxt = RSP_NACK;
        end else if (r_pend_ack) begin
          w_resp_nxt = RSP_ACK;
        end else if (w_sel_nack) begin
          w_resp_nxt = RSP_NACK;
        end else if (w_sel_ack) begin
          w_resp_nxt   = RSP_ACK;
          w_rdata_load = !r_req.wr;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_resp_nxt = RSP_TIMEOUT;
          w_cnt_nxt  = r_cnt + 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt     = ST_IDLE;
        w_cnt_nxt       = '0;
        w_pend_ack_nxt  = 1'b0;
        w_pend_nack_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_resp      <= RSP_ACK;
      r_req       <= '0;
      r_cnt       <= '0;
      r_pend_ack  <= 1'b0;
      r_pend_nack <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_resp      <= w_resp_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_ack  <= w_pend_ack_nxt;
      r_pend_nack <= w_pend_nack_nxt;
      if (w_accept) begin
        r_req.wr    <= bus.wr;
        r_req.sel   <= bus.addr[15:12];
        r_req.off   <= bus.addr[11:0];
        r_req.wdata <= bus.data;
      end
      if (w_rdata_load) begin
        r_rdata <= w_sel_rdata;
      end
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.ack     = (r_state == ST_RESP) && (r_resp == RSP_ACK);
  assign bus.nack    = (r_state == ST_RESP) && (r_resp == RSP_NACK);
  assign bus.unknown = (r_state == ST_RESP) && (r_resp == RSP_UNKNOWN);
  assign bus.timeout = (r_state == ST_RESP) && (r_resp == RSP_TIMEOUT);
  assign bus.s_wr    = (r_state == ST_STROBE && r_req.wr)  ? w_onehot : '0;
  assign bus.s_rd    = (r_state == ST_STROBE && !r_req.wr) ? w_onehot : '0;
  assign bus.s_addr  = r_req.off;
  assign bus.s_wdata = r_req.wdata;
  assign bus.rdata   = r_rdata;

endmodule
